// File: rtl/tx_ltssm_os_sequencer_pkg.sv
// Shared constants, state encoding and per-substate transmit table for the
// transmit-side LTSSM ordered-set sequencer.
package tx_ltssm_os_sequencer_pkg;

    localparam int unsigned LANE_BITS = 128;
    localparam int unsigned MIN_CNT_W = 11;

    // LTSSM substate codes shared with the receive LTSSM
    localparam logic [4:0] POLLING_ACTIVE         = 5'd1;
    localparam logic [4:0] POLLING_CONFIG         = 5'd2;
    localparam logic [4:0] CONFIG_LINKWIDTH_START = 5'd4;
    localparam logic [4:0] CONFIG_COMPLETE        = 5'd5;
    localparam logic [4:0] RECOVERY_RCVRLOCK      = 5'd9;
    localparam logic [4:0] RECOVERY_EQ            = 5'd12;
    localparam logic [4:0] RECOVERY_IDLE          = 5'd13;

    // Symbol constants
    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] PAD       = 8'hF7;
    localparam logic [7:0] N_FTS     = 8'hFF;
    localparam logic [7:0] TS1_ID    = 8'h4A;
    localparam logic [7:0] TS2_ID    = 8'h45;
    localparam logic [7:0] TS1_ID_G3 = 8'h1E;
    localparam logic [7:0] TS2_ID_G3 = 8'h2D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef enum logic {
        OS_TS1 = 1'b0,
        OS_TS2 = 1'b1
    } os_type_e;

    typedef struct packed {
        logic [MIN_CNT_W-1:0] min_count;
        os_type_e             os_type;
        logic                 eq;
    } substate_cfg_t;

    // Minimum transmit count, set type and EQ flag for a substate code.
    // Unknown codes fall back to zero count, TS1, no EQ.
    function automatic substate_cfg_t lookup_substate(input logic [4:0] code);
        substate_cfg_t cfg;
        cfg.min_count = 11'd0;
        cfg.os_type   = OS_TS1;
        cfg.eq        = 1'b0;
        case (code)
            POLLING_ACTIVE:         begin cfg.min_count = 11'd1024; cfg.os_type = OS_TS1; end
            POLLING_CONFIG:         begin cfg.min_count = 11'd16;   cfg.os_type = OS_TS2; end
            CONFIG_LINKWIDTH_START: begin cfg.min_count = 11'd0;    cfg.os_type = OS_TS1; end
            CONFIG_COMPLETE:        begin cfg.min_count = 11'd16;   cfg.os_type = OS_TS2; end
            RECOVERY_RCVRLOCK:      begin cfg.min_count = 11'd0;    cfg.os_type = OS_TS1; end
            RECOVERY_EQ:            begin cfg.min_count = 11'd0;    cfg.os_type = OS_TS1; cfg.eq = 1'b1; end
            RECOVERY_IDLE:          begin cfg.min_count = 11'd0;    cfg.os_type = OS_TS1; end
            default:                begin cfg.min_count = 11'd0;    cfg.os_type = OS_TS1; cfg.eq = 1'b0; end
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/tx_ltssm_os_sequencer_ts_lane_builder.sv
// Combinational builder for one lane's 16-symbol TS1/TS2 ordered set.
module ts_lane_builder
    import tx_ltssm_os_sequencer_pkg::*;
#(
    parameter int DEVICETYPE = 0
) (
    input  logic [3:0]   lane_idx,
    input  logic [2:0]   gen,
    input  logic [7:0]   link_number,
    input  logic [4:0]   num_lanes,
    input  logic [7:0]   rate_id,
    input  logic         up_cfg,
    input  os_type_e     os_type,
    input  logic         eq_flag,
    input  logic [3:0]   tx_preset,
    input  logic [2:0]   rx_preset,
    output logic [127:0] lane_set,
    output logic         lane_active
);

    logic [7:0] id_sym_s;
    logic [7:0] sym0_s;
    logic [7:0] sym6_s;

    // Assemble symbols for this lane; lanes beyond the active count stay all zero.
    always_comb begin
        lane_active = ({1'b0, lane_idx} < num_lanes);
        id_sym_s    = (os_type == OS_TS2) ? TS2_ID : TS1_ID;

        if (gen <= 3'd2) begin
            sym0_s = COM;
        end else if (os_type == OS_TS2) begin
            sym0_s = TS2_ID_G3;
        end else begin
            sym0_s = TS1_ID_G3;
        end

        // Downstream ports advertise presets in EQ sets; upstream ports send the ID
        if (eq_flag && (DEVICETYPE == 1)) begin
            sym6_s = {1'b0, rx_preset, tx_preset};
        end else begin
            sym6_s = id_sym_s;
        end

        lane_set = '0;
        if (lane_active) begin
            lane_set[7:0]   = sym0_s;
            lane_set[15:8]  = link_number;
            lane_set[23:16] = {4'd0, lane_idx};
            lane_set[31:24] = N_FTS;
            lane_set[39:32] = rate_id;
            lane_set[47:40] = {1'b0, up_cfg, 6'd0};
            lane_set[55:48] = sym6_s;
            for (int k = 7; k < 16; k++) begin
                lane_set[k*8 +: 8] = id_sym_s;
            end
        end else begin
            lane_set = '0;
        end
    end

endmodule

// File: rtl/tx_ltssm_os_sequencer.sv
// Transmit-side LTSSM ordered-set sequencer: builds per-lane TS1/TS2 sets for
// the commanded substate, counts accepted sets and signals completion.
module tx_ltssm_os_sequencer
    import tx_ltssm_os_sequencer_pkg::*;
#(
    parameter int DEVICETYPE = 0,
    parameter int MAXLANES   = 16,
    parameter int CNTW       = 11
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [4:0]                      substate,
    input  logic [2:0]                      Gen,
    input  logic [7:0]                      linkNumber,
    input  logic [4:0]                      numberOfDetectedLanes,
    input  logic [7:0]                      rateId,
    input  logic                            upConfigureCapability,
    input  logic [4*MAXLANES-1:0]           TransmitterPresetHint,
    input  logic [3*MAXLANES-1:0]           ReceiverpresetHint,
    input  logic                            rxDone,
    input  logic                            osReady,
    output logic [MAXLANES*LANE_BITS-1:0]   orderedSets,
    output logic                            validOrderedSets,
    output logic [MAXLANES-1:0]             laneMask,
    output logic                            finish,
    output logic [CNTW-1:0]                 txCount
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    seq_state_e                      state_q, state_d;
    logic [MAXLANES*LANE_BITS-1:0]   os_q, os_d;
    logic [MAXLANES-1:0]             mask_q, mask_d;
    logic                            valid_q, valid_d;
    logic                            finish_q, finish_d;
    logic [CNTW-1:0]                 cnt_q, cnt_d;
    logic [MIN_CNT_W-1:0]            min_q, min_d;

    substate_cfg_t                   cfg_s;
    logic [4:0]                      num_lanes_s;
    logic [MAXLANES*LANE_BITS-1:0]   os_build_s;
    logic [MAXLANES-1:0]             mask_build_s;

    // Table lookup and lane-count clamp; a lane count of zero means one lane
    always_comb begin
        cfg_s = lookup_substate(substate);
        if (numberOfDetectedLanes == 5'd0) begin
            num_lanes_s = 5'd1;
        end else begin
            num_lanes_s = numberOfDetectedLanes;
        end
    end

    for (genvar i = 0; i < MAXLANES; i++) begin : g_lane
        ts_lane_builder #(
            .DEVICETYPE (DEVICETYPE)
        ) u_lane (
            .lane_idx    (4'(i)),
            .gen         (Gen),
            .link_number (linkNumber),
            .num_lanes   (num_lanes_s),
            .rate_id     (rateId),
            .up_cfg      (upConfigureCapability),
            .os_type     (cfg_s.os_type),
            .eq_flag     (cfg_s.eq),
            .tx_preset   (TransmitterPresetHint[i*4 +: 4]),
            .rx_preset   (ReceiverpresetHint[i*3 +: 3]),
            .lane_set    (os_build_s[i*LANE_BITS +: LANE_BITS]),
            .lane_active (mask_build_s[i])
        );
    end

    // Next-state and output logic; a start in SEND or DONE restarts via LOAD
    always_comb begin
        state_d  = state_q;
        os_d     = os_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        finish_d = 1'b0;
        cnt_d    = cnt_q;
        min_d    = min_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                os_d    = os_build_s;
                mask_d  = mask_build_s;
                min_d   = cfg_s.min_count;
                cnt_d   = '0;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (start) begin
                    valid_d = 1'b0;
                    state_d = ST_LOAD;
                end else begin
                    if (osReady && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    // Compare the post-increment count so finish does not lag a cycle
                    if ((32'(cnt_d) >= 32'(min_q)) && rxDone) begin
                        valid_d  = 1'b0;
                        finish_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        valid_d  = 1'b1;
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            os_q     <= '0;
            mask_q   <= '0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
            cnt_q    <= '0;
            min_q    <= '0;
        end else begin
            state_q  <= state_d;
            os_q     <= os_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
            cnt_q    <= cnt_d;
            min_q    <= min_d;
        end
    end

    assign orderedSets      = os_q;
    assign validOrderedSets = valid_q;
    assign laneMask         = mask_q;
    assign finish           = finish_q;
    assign txCount          = cnt_q;

endmodule
